// File: rtl/vga_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_rx : VGA timing decoder with geometry lock and pixel write strobe    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_START     = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        we,
  output logic [8:0]  wr_row,
  output logic [9:0]  wr_col,
  output logic [11:0] wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        err
);

  localparam logic [9:0] c_H_TOTAL  = 10'(H_TOTAL);
  localparam logic [9:0] c_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_H_SYNC   = 10'(H_SYNC);
  localparam logic [9:0] c_H_VIS0   = 10'(H_START);
  localparam logic [9:0] c_H_VIS1   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] c_V_TOTAL  = 10'(V_TOTAL);
  localparam logic [9:0] c_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_V_VIS0   = 10'(V_START);
  localparam logic [9:0] c_V_VIS1   = 10'(V_START + V_ACTIVE);
  localparam logic [8:0] c_ROW_LAST = 9'(V_ACTIVE - 1);
  localparam logic [9:0] c_COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] c_CNT_MAX  = 10'h3FF;
  localparam int         c_GW       = $clog2(LOCK_FRAMES + 1);
  localparam logic [c_GW-1:0] c_LOCK = c_GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  logic            r_hs, r_vs, r_hs_d, r_vs_d;
  logic [11:0]     r_rgb;
  logic [9:0]      r_hcnt, r_vcnt;
  logic            r_vpend, r_hvalid, r_vvalid;
  state_t          r_state, w_state_nxt;
  logic [c_GW-1:0] r_good, w_good_nxt, w_good_inc;

  logic            w_ls, w_hr, w_vf, w_vpend, w_fs;
  logic [9:0]      w_hcnt, w_vcnt, w_col;
  logic [8:0]      w_row;
  logic            w_viol, w_vis, w_wr;

  logic            r_we, r_fd, r_err, r_locked;
  logic [8:0]      r_wr_row;
  logic [9:0]      r_wr_col;
  logic [11:0]     r_wr_data;

  // S1 input stage plus the previous hs/vs sample for edge detection
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
      r_rgb  <= '0;
    end else begin
      r_hs   <= hs;
      r_vs   <= vs;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_rgb  <= {b, g, r};
    end
  end

  assign w_ls    = r_hs_d & ~r_hs;
  assign w_hr    = ~r_hs_d & r_hs;
  assign w_vf    = r_vs_d & ~r_vs;
  assign w_vpend = r_vpend | w_vf;
  assign w_fs    = w_ls & w_vpend;

  always_comb begin
    w_hcnt = r_hcnt;
    if (w_ls)
      w_hcnt = '0;
    else if (r_hcnt != c_CNT_MAX)
      w_hcnt = r_hcnt + 10'd1;
  end

  always_comb begin
    w_vcnt = r_vcnt;
    if (w_fs)
      w_vcnt = '0;
    else if (w_ls && (r_vcnt != c_CNT_MAX))
      w_vcnt = r_vcnt + 10'd1;
  end

  assign w_viol = (w_hr && (w_hcnt != c_H_SYNC))
               || (w_ls && r_hvalid && (r_hcnt != c_H_LAST))
               || (w_hcnt == c_H_TOTAL)
               || (w_fs && r_vvalid && (r_vcnt != c_V_LAST))
               || (w_ls && !w_vpend && (w_vcnt == c_V_TOTAL));

  assign w_vis = (w_hcnt >= c_H_VIS0) && (w_hcnt < c_H_VIS1)
              && (w_vcnt >= c_V_VIS0) && (w_vcnt < c_V_VIS1);
  assign w_col = w_hcnt - c_H_VIS0;
  assign w_row = 9'(w_vcnt - c_V_VIS0);
  assign w_wr  = (r_state == S_LOCKED) && w_vis && !w_viol;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_vpend  <= 1'b0;
      r_hvalid <= 1'b0;
      r_vvalid <= 1'b0;
    end else begin
      r_hcnt  <= w_hcnt;
      r_vcnt  <= w_vcnt;
      r_vpend <= w_vpend & ~w_fs;
      if (w_viol)
        r_hvalid <= 1'b0;
      else if (w_ls)
        r_hvalid <= 1'b1;
      if (w_fs)
        r_vvalid <= 1'b1;
    end
  end

  assign w_good_inc = r_good + 1'b1;

  // HUNT leaves on a frame-start line so a mid-line vs edge never counts a partial frame
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      S_HUNT: begin
        if (w_fs) begin
          w_state_nxt = S_MEASURE;
          w_good_nxt  = '0;
        end
      end
      S_MEASURE: begin
        if (w_fs) begin
          if (w_good_inc == c_LOCK)
            w_state_nxt = S_LOCKED;
          else
            w_good_nxt = w_good_inc;
        end
      end
      S_LOCKED: begin
        w_state_nxt = S_LOCKED;
      end
      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase
    if (w_viol) begin
      w_state_nxt = S_HUNT;
      w_good_nxt  = '0;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HUNT;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_fd      <= 1'b0;
      r_err     <= 1'b0;
      r_locked  <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_data <= '0;
    end else begin
      r_we     <= w_wr;
      r_fd     <= w_wr && (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
      r_err    <= w_viol;
      r_locked <= (w_state_nxt == S_LOCKED);
      if (w_wr) begin
        r_wr_row  <= w_row;
        r_wr_col  <= w_col;
        r_wr_data <= r_rgb;
      end
    end
  end

  assign we         = r_we;
  assign wr_row     = r_wr_row;
  assign wr_col     = r_wr_col;
  assign wr_data    = r_wr_data;
  assign locked     = r_locked;
  assign frame_done = r_fd;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_rx : frame-level vectors on a reduced raster for vga_rx           |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vga_rx;

  localparam int HT   = 40;
  localparam int HSY  = 6;
  localparam int HST  = 10;
  localparam int HA   = 24;
  localparam int VT   = 16;
  localparam int VST  = 3;
  localparam int VA   = 10;
  localparam int NPIX = HA * VA;
  localparam int NV   = 21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs;
  logic [3:0]  rr, gg, bb;
  logic        we, locked, frame_done, err;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;

  vga_rx #(
    .H_TOTAL(HT), .H_SYNC(HSY), .H_START(HST), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs),
    .r(rr), .g(gg), .b(bb),
    .we(we), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .locked(locked), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nlines;
    int short_line;
    int bad_hs_line;
    int rst_line;
    int exp_err;
    int exp_we;
    int exp_fd;
    int exp_lock;
  } vec_t;

  vec_t vecs [NV];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tx_line = 0;
  int tx_ls_cyc = 0;
  int n_we = 0;
  int n_fd = 0;
  int n_err = 0;
  int we_at_rst = 0;
  logic prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int idx, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", nm, idx, act, exp_v);
    end
  endtask

  // Pixel stream model: row/col/data are rebuilt from the transmitter's own position
  always @(negedge clk) begin : mon
    int er, ec;
    logic [11:0] ed;
    logic last;
    if (prev_err) begin
      check("err_single_pulse", cyc, int'(err), 0);
      check("locked_after_err", cyc, int'(locked), 0);
    end
    prev_err = err;
    if (err) n_err++;
    if (frame_done) n_fd++;
    er = tx_line - VST;
    ec = cyc - tx_ls_cyc - HST - 2;
    ed = {4'(er), 8'(ec)};
    last = we && (er == VA - 1) && (ec == HA - 1);
    if (we) begin
      n_we++;
      n_checks++;
      if (int'(wr_row) != er || int'(wr_col) != ec || wr_data != ed) begin
        n_errors++;
        $display("FAIL pixel @cyc %0d: got row=%0d col=%0d data=%h, expected row=%0d col=%0d data=%h",
                 cyc, wr_row, wr_col, wr_data, er, ec, ed);
      end
    end
    if (frame_done || last)
      check("frame_done", cyc, int'(frame_done), int'(last));
  end

  task automatic tx_frame(input vec_t v);
    int len, hw;
    for (int l = 0; l < v.nlines; l++) begin
      len = (l == v.short_line) ? HT - 1 : HT;
      hw  = (l == v.bad_hs_line) ? HSY - 1 : HSY;
      for (int x = 0; x < len; x++) begin
        @(posedge clk);
        #1;
        if (x == 0) begin
          tx_line   = l;
          tx_ls_cyc = cyc;
        end
        hs = (x >= hw);
        vs = (l >= 2);
        if (x >= HST && x < HST + HA && l >= VST && l < VST + VA)
          {bb, gg, rr} = {4'(l - VST), 8'(x - HST)};
        else
          {bb, gg, rr} = 12'h000;
        if (l == v.rst_line && x == 15) begin
          #2;
          check("we_before_rst", l, int'(we), 1);
          rst_n = 1'b0;
          #1;
          check("async_clear", l,
                int'(we) + int'(locked) + int'(frame_done) + int'(err)
                + int'(wr_row != 0) + int'(wr_col != 0) + int'(wr_data != 0), 0);
          we_at_rst = n_we;
        end
        if (l == v.rst_line && x == 20) begin
          #2;
          rst_n = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int e0, w0, f0;
    vecs[0]  = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[1]  = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[2]  = '{VT,     -1, -1, -1, 0, NPIX,   1, 1};
    vecs[3]  = '{VT,     -1, -1, -1, 0, NPIX,   1, 1};
    vecs[4]  = '{VT,      5, -1, -1, 1, 3 * HA, 0, 0};
    vecs[5]  = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[6]  = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[7]  = '{VT,     -1, -1, -1, 0, NPIX,   1, 1};
    vecs[8]  = '{VT,     -1,  4, -1, 1, HA,     0, 0};
    vecs[9]  = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[10] = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[11] = '{VT,     -1, -1, -1, 0, NPIX,   1, 1};
    vecs[12] = '{VT - 1, -1, -1, -1, 0, NPIX,   1, 1};
    vecs[13] = '{VT,     -1, -1, -1, 1, 0,      0, 0};
    vecs[14] = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[15] = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[16] = '{VT,     -1, -1, -1, 0, NPIX,   1, 1};
    vecs[17] = '{VT,     -1, -1,  8, 0, -1,     0, 0};
    vecs[18] = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[19] = '{VT,     -1, -1, -1, 0, 0,      0, 0};
    vecs[20] = '{VT,     -1, -1, -1, 0, NPIX,   1, 1};

    rst_n = 1'b0;
    hs = 1'b1; vs = 1'b1; {bb, gg, rr} = 12'h000;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      hs = 1'($urandom);
      vs = 1'($urandom);
      {bb, gg, rr} = 12'($urandom);
      @(negedge clk);
      check("reset_outputs", i,
            int'(we) + int'(locked) + int'(frame_done) + int'(err)
            + int'(wr_row != 0) + int'(wr_col != 0) + int'(wr_data != 0), 0);
    end
    @(posedge clk);
    #1;
    hs = 1'b1; vs = 1'b1; {bb, gg, rr} = 12'h000;
    #2 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("idle_we", 0, n_we, 0);
    check("idle_locked", 0, int'(locked), 0);

    for (int i = 0; i < NV; i++) begin
      e0 = n_err; w0 = n_we; f0 = n_fd;
      tx_frame(vecs[i]);
      check("err_count", i, n_err - e0, vecs[i].exp_err);
      if (vecs[i].exp_we >= 0)
        check("we_count", i, n_we - w0, vecs[i].exp_we);
      check("frame_done_count", i, n_fd - f0, vecs[i].exp_fd);
      check("locked_at_end", i, int'(locked), vecs[i].exp_lock);
      if (vecs[i].rst_line >= 0)
        check("no_we_after_rst", i, n_we - we_at_rst, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
